// File: rtl/freq_meter_pkg.sv
// Shared constants for the clock frequency meter: FSM state encoding and default sizing.
package freq_meter_pkg;

    localparam int unsigned DEF_GATE_CYCLES = 1000;
    localparam int unsigned DEF_CNT_W       = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GATE = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/clk_freq_meter_if.sv
// Request/result bundle of the frequency meter. The meter is the slave side; the
// requester that issues start and consumes the count is the master side.
interface clk_freq_meter_if #(
    parameter int unsigned CNT_W = freq_meter_pkg::DEF_CNT_W
);

    logic             start;
    logic             busy;
    logic [CNT_W-1:0] cnt_out;
    logic             cnt_valid;
    logic             overflow;
    logic             in_range;

    modport master (
        output start,
        input  busy,
        input  cnt_out,
        input  cnt_valid,
        input  overflow,
        input  in_range
    );

    modport slave (
        input  start,
        output busy,
        output cnt_out,
        output cnt_valid,
        output overflow,
        output in_range
    );

endinterface

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer plus one delay flop; rise pulses for one cycle per rising edge of din.
module sync_edge_det (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic din,
    output logic rise
);

    logic sync1_q;
    logic sync2_q;
    logic delay_q;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            delay_q <= 1'b0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
            delay_q <= sync2_q;
        end
    end

    assign rise = sync2_q & ~delay_q;

endmodule

// File: rtl/clk_freq_meter.sv
// Gated edge counter: counts rising edges of meas_in over GATE_CYCLES sys_clk cycles.
// Define FREQ_METER_RANGE_CHECK_EN to build the [EXP_MIN, EXP_MAX] in_range check.
module clk_freq_meter
    import freq_meter_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = DEF_GATE_CYCLES,
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned EXP_MIN     = 0,
    parameter int unsigned EXP_MAX     = (2 ** CNT_W) - 1
) (
    input logic             sys_clk,
    input logic             sys_rst,
    input logic             meas_in,
    clk_freq_meter_if.slave bus
);

    localparam int unsigned GATE_W = $clog2(GATE_CYCLES);

    if (GATE_CYCLES < 2) begin : g_bad_gate
        $error("GATE_CYCLES must be at least 2");
    end
    if (EXP_MIN > EXP_MAX) begin : g_bad_range
        $error("EXP_MIN must not exceed EXP_MAX");
    end

    state_e             state_q, state_d;
    logic [GATE_W-1:0]  gate_cnt_q, gate_cnt_d;
    logic [CNT_W-1:0]   edge_cnt_q, edge_cnt_d;
    logic [CNT_W-1:0]   cnt_out_q, cnt_out_d;
    logic               sat_q, sat_d;
    logic               overflow_q, overflow_d;
    logic               rise;
    logic               gate_last;

    sync_edge_det u_sync_edge_det (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .din     (meas_in),
        .rise    (rise)
    );

    assign gate_last = (state_q == GATE) && (gate_cnt_q == '0);

    always_comb begin
        state_d    = state_q;
        gate_cnt_d = gate_cnt_q;
        edge_cnt_d = edge_cnt_q;
        sat_d      = sat_q;
        cnt_out_d  = cnt_out_q;
        overflow_d = overflow_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d    = GATE;
                    gate_cnt_d = GATE_W'(GATE_CYCLES - 1);
                    edge_cnt_d = '0;
                    sat_d      = 1'b0;
                end
            end
            GATE: begin
                if (rise) begin
                    if (&edge_cnt_q) begin
                        sat_d = 1'b1;
                    end else begin
                        edge_cnt_d = edge_cnt_q + 1'b1;
                    end
                end
                // Result is captured as DONE is entered so it is visible with cnt_valid.
                if (gate_cnt_q == '0) begin
                    state_d    = DONE;
                    cnt_out_d  = edge_cnt_d;
                    overflow_d = sat_d;
                end else begin
                    gate_cnt_d = gate_cnt_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q    <= IDLE;
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
            sat_q      <= 1'b0;
            cnt_out_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            gate_cnt_q <= gate_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            sat_q      <= sat_d;
            cnt_out_q  <= cnt_out_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef FREQ_METER_RANGE_CHECK_EN
    localparam logic [CNT_W:0] EXP_MIN_C = (CNT_W + 1)'(EXP_MIN);
    localparam logic [CNT_W:0] EXP_MAX_C = (CNT_W + 1)'(EXP_MAX);

    logic in_range_q;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            in_range_q <= 1'b0;
        end else if (gate_last) begin
            in_range_q <= !sat_d && ({1'b0, edge_cnt_d} >= EXP_MIN_C)
                                 && ({1'b0, edge_cnt_d} <= EXP_MAX_C);
        end
    end

    assign bus.in_range = in_range_q;
`else
    assign bus.in_range = 1'b0;
`endif

    assign bus.busy      = (state_q != IDLE);
    assign bus.cnt_valid = (state_q == DONE);
    assign bus.cnt_out   = cnt_out_q;
    assign bus.overflow  = overflow_q;

endmodule
